// File: rtl/urv_csr_mbx.sv
// urv_csr_mbx: CSR read/write unit with scratch registers, counters and
// a host<->core debug mailbox (two FIFOs plus status register).
module urv_csr_mbx #(
   parameter int g_counter_width = 40,
   parameter int g_num_scratch   = 1,
   parameter int g_mbx_depth     = 4,
   parameter int g_with_hw_debug = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       x_stall_i,
   input  logic                       x_kill_i,
   input  logic                       d_is_csr_i,
   input  logic [2:0]                 d_fun_i,
   input  logic [4:0]                 d_csr_imm_i,
   input  logic [11:0]                d_csr_sel_i,
   input  logic [31:0]                d_rs1_i,
   output logic [31:0]                x_rd_o,
   output logic [31:0]                x_csr_write_value_o,
   input  logic [g_counter_width-1:0] csr_time_i,
   input  logic [g_counter_width-1:0] csr_cycles_i,
   input  logic [31:0]                csr_mstatus_i,
   input  logic [31:0]                csr_mip_i,
   input  logic [31:0]                csr_mie_i,
   input  logic [31:0]                csr_mepc_i,
   input  logic [31:0]                csr_mcause_i,
   input  logic [31:0]                dbg_h2c_data_i,
   input  logic                       dbg_h2c_valid_i,
   output logic                       dbg_h2c_ready_o,
   output logic [31:0]                dbg_c2h_data_o,
   output logic                       dbg_c2h_valid_o,
   input  logic                       dbg_c2h_ready_i,
   output logic                       mbx_irq_o
);
   localparam int PW = $clog2(g_mbx_depth);
   localparam int LW = PW + 1;
   localparam logic [11:0] CSR_MSTATUS = 12'h300, CSR_MIE = 12'h304, CSR_MSCRATCH = 12'h340,
      CSR_MEPC = 12'h341, CSR_MCAUSE = 12'h342, CSR_MIP = 12'h344, CSR_CYCLESL = 12'hC00,
      CSR_TIMEL = 12'hC01, CSR_CYCLESH = 12'hC80, CSR_TIMEH = 12'hC81, CSR_DBGMBX = 12'h7D0,
      CSR_MBXSTAT = 12'h7C8;

   logic        w_commit;
   logic [31:0] w_rd, w_opnd, w_wval, w_h2c_head, w_mbxstat;
   logic [1:0]  w_scr_idx;
   logic        w_scr_hit;
   logic [31:0] r_scratch [4];

   assign w_commit            = d_is_csr_i & ~x_stall_i & ~x_kill_i;
   assign w_opnd              = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
   assign w_wval              = (d_fun_i[1:0] == 2'b01) ? w_opnd :
                                (d_fun_i[1:0] == 2'b10) ? (w_rd | w_opnd) : (w_rd & ~w_opnd);
   assign x_rd_o              = w_rd;
   assign x_csr_write_value_o = w_wval;
   // MSCRATCH is slot 0; SCRATCH1..3 map their low address bits onto slots 1..3
   assign w_scr_idx = (d_csr_sel_i == CSR_MSCRATCH) ? 2'd0 : d_csr_sel_i[1:0];
   assign w_scr_hit = ((d_csr_sel_i == CSR_MSCRATCH) ||
                       (d_csr_sel_i >= 12'h7C1 && d_csr_sel_i <= 12'h7C3)) &&
                      (int'(w_scr_idx) < g_num_scratch);

   always_comb begin
      w_rd = '0;
      case (d_csr_sel_i)
         CSR_CYCLESL: w_rd = csr_cycles_i[31:0];
         CSR_CYCLESH: w_rd = 32'(csr_cycles_i[g_counter_width-1:32]);
         CSR_TIMEL:   w_rd = csr_time_i[31:0];
         CSR_TIMEH:   w_rd = 32'(csr_time_i[g_counter_width-1:32]);
         CSR_MEPC:    w_rd = csr_mepc_i;
         CSR_MSTATUS: w_rd = csr_mstatus_i;
         CSR_MCAUSE:  w_rd = csr_mcause_i;
         CSR_MIP:     w_rd = csr_mip_i;
         CSR_MIE:     w_rd = csr_mie_i;
         CSR_DBGMBX:  w_rd = w_h2c_head;
         CSR_MBXSTAT: w_rd = w_mbxstat;
         default:     w_rd = w_scr_hit ? r_scratch[w_scr_idx] : '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i)
         for (int k = 0; k < 4; k++) r_scratch[k] <= '0;
      else if (w_commit && w_scr_hit)
         r_scratch[w_scr_idx] <= w_wval;

   if (g_with_hw_debug != 0) begin : g_mbx
      logic [31:0]   r_h2c_mem [g_mbx_depth];
      logic [31:0]   r_c2h_mem [g_mbx_depth];
      logic [PW-1:0] r_h2c_rp, r_h2c_wp, r_c2h_rp, r_c2h_wp;
      logic [LW-1:0] r_h2c_lvl, r_c2h_lvl;
      logic          r_ovf, r_irq;
      logic          w_acc, w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;
      logic          w_h2c_push, w_h2c_pop, w_c2h_push, w_c2h_drop, w_c2h_pop, w_ovf_clr;

      assign w_acc       = w_commit && d_csr_sel_i == CSR_DBGMBX;
      assign w_h2c_full  = r_h2c_lvl == LW'(g_mbx_depth);
      assign w_h2c_empty = r_h2c_lvl == '0;
      assign w_c2h_full  = r_c2h_lvl == LW'(g_mbx_depth);
      assign w_c2h_empty = r_c2h_lvl == '0;
      assign w_h2c_push  = dbg_h2c_valid_i & ~w_h2c_full;
      assign w_h2c_pop   = w_acc & ~w_h2c_empty;
      // fullness is judged on the pre-cycle level, so a same-cycle host pop cannot rescue the push
      assign w_c2h_push  = w_acc && d_fun_i[1:0] == 2'b01 && !w_c2h_full;
      assign w_c2h_drop  = w_acc && d_fun_i[1:0] == 2'b01 && w_c2h_full;
      assign w_c2h_pop   = ~w_c2h_empty & dbg_c2h_ready_i;
      assign w_ovf_clr   = w_commit && d_csr_sel_i == CSR_MBXSTAT && !w_wval[2];

      always_ff @(posedge clk_i) begin
         if (w_h2c_push) r_h2c_mem[r_h2c_wp] <= dbg_h2c_data_i;
         if (w_c2h_push) r_c2h_mem[r_c2h_wp] <= w_wval;
      end

      always_ff @(posedge clk_i or negedge rst_n_i)
         if (!rst_n_i) begin
            r_h2c_rp  <= '0;
            r_h2c_wp  <= '0;
            r_c2h_rp  <= '0;
            r_c2h_wp  <= '0;
            r_h2c_lvl <= '0;
            r_c2h_lvl <= '0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
         end else begin
            if (w_h2c_push) r_h2c_wp <= r_h2c_wp + PW'(1);
            if (w_h2c_pop)  r_h2c_rp <= r_h2c_rp + PW'(1);
            if (w_c2h_push) r_c2h_wp <= r_c2h_wp + PW'(1);
            if (w_c2h_pop)  r_c2h_rp <= r_c2h_rp + PW'(1);
            r_h2c_lvl <= r_h2c_lvl + LW'(w_h2c_push) - LW'(w_h2c_pop);
            r_c2h_lvl <= r_c2h_lvl + LW'(w_c2h_push) - LW'(w_c2h_pop);
            r_ovf     <= w_c2h_drop ? 1'b1 : w_ovf_clr ? 1'b0 : r_ovf;
            r_irq     <= ~w_h2c_empty;
         end

      assign dbg_h2c_ready_o = ~w_h2c_full;
      assign dbg_c2h_valid_o = ~w_c2h_empty;
      assign dbg_c2h_data_o  = w_c2h_empty ? '0 : r_c2h_mem[r_c2h_rp];
      assign w_h2c_head      = w_h2c_empty ? '0 : r_h2c_mem[r_h2c_rp];
      assign w_mbxstat       = {8'b0, 8'(r_c2h_lvl), 8'(r_h2c_lvl), 5'b0, r_ovf, w_c2h_full, ~w_h2c_empty};
      assign mbx_irq_o       = r_irq;
   end else begin : g_no_mbx
      assign dbg_h2c_ready_o = 1'b0;
      assign dbg_c2h_valid_o = 1'b0;
      assign dbg_c2h_data_o  = '0;
      assign w_h2c_head      = '0;
      assign w_mbxstat       = '0;
      assign mbx_irq_o       = 1'b0;
   end
endmodule

// File: tb/tb_urv_csr_mbx.sv
// tb_urv_csr_mbx: directed self-checking bench for urv_csr_mbx (48-bit counters, depth 4).
module tb_urv_csr_mbx;
   logic        clk_i = 1'b0, rst_n_i = 1'b0;
   logic        x_stall_i = 0, x_kill_i = 0, d_is_csr_i = 0;
   logic [2:0]  d_fun_i = 0;
   logic [4:0]  d_csr_imm_i = 0;
   logic [11:0] d_csr_sel_i = 0;
   logic [31:0] d_rs1_i = 0;
   logic [31:0] x_rd_o, x_csr_write_value_o;
   logic [47:0] csr_time_i = 48'h0001_8765_4321, csr_cycles_i = 48'hABCD_1234_5678;
   logic [31:0] csr_mstatus_i = 32'h1888, csr_mip_i = 32'h80, csr_mie_i = 32'h808;
   logic [31:0] csr_mepc_i = 32'hDEAD_BEE0, csr_mcause_i = 32'h8000_0007;
   logic [31:0] dbg_h2c_data_i = 0, dbg_c2h_data_o;
   logic        dbg_h2c_valid_i = 0, dbg_h2c_ready_o, dbg_c2h_valid_o, dbg_c2h_ready_i = 0, mbx_irq_o;
   int          n_checks = 0, n_err = 0;

   localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RCI = 3'b111;
   localparam logic [11:0] MSCR = 12'h340, SCR1 = 12'h7C1, DBG = 12'h7D0, STAT = 12'h7C8;

   urv_csr_mbx #(.g_counter_width(48), .g_num_scratch(1), .g_mbx_depth(4), .g_with_hw_debug(1)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
      .d_is_csr_i(d_is_csr_i), .d_fun_i(d_fun_i), .d_csr_imm_i(d_csr_imm_i),
      .d_csr_sel_i(d_csr_sel_i), .d_rs1_i(d_rs1_i), .x_rd_o(x_rd_o),
      .x_csr_write_value_o(x_csr_write_value_o), .csr_time_i(csr_time_i),
      .csr_cycles_i(csr_cycles_i), .csr_mstatus_i(csr_mstatus_i), .csr_mip_i(csr_mip_i),
      .csr_mie_i(csr_mie_i), .csr_mepc_i(csr_mepc_i), .csr_mcause_i(csr_mcause_i),
      .dbg_h2c_data_i(dbg_h2c_data_i), .dbg_h2c_valid_i(dbg_h2c_valid_i),
      .dbg_h2c_ready_o(dbg_h2c_ready_o), .dbg_c2h_data_o(dbg_c2h_data_o),
      .dbg_c2h_valid_o(dbg_c2h_valid_o), .dbg_c2h_ready_i(dbg_c2h_ready_i), .mbx_irq_o(mbx_irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic csr(input logic [2:0] f, input logic [11:0] s, input logic [31:0] r, input logic [4:0] z);
      d_is_csr_i = 1; d_fun_i = f; d_csr_sel_i = s; d_rs1_i = r; d_csr_imm_i = z;
      #1;
   endtask

   task automatic peek(input logic [11:0] s);
      d_is_csr_i = 0; d_csr_sel_i = s;
      #1;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst_ready", 32'(dbg_h2c_ready_o), 1);
      chk("rst_c2h_valid", 32'(dbg_c2h_valid_o), 0);
      chk("rst_c2h_data", dbg_c2h_data_o, 0);
      chk("rst_irq", 32'(mbx_irq_o), 0);
      peek(MSCR); chk("rst_mscratch", x_rd_o, 0);
      tick(); tick();
      rst_n_i = 1;
      tick();
      // scratch read-modify-write
      csr(RW, MSCR, 32'hF0, 0);
      chk("rw_rd", x_rd_o, 0); chk("rw_wval", x_csr_write_value_o, 32'hF0);
      tick();
      csr(RS, MSCR, 32'h0F, 0);
      chk("rs_rd", x_rd_o, 32'hF0); chk("rs_wval", x_csr_write_value_o, 32'hFF);
      tick();
      peek(MSCR); chk("mscratch_ff", x_rd_o, 32'hFF);
      x_stall_i = 1; csr(RS, MSCR, 32'h100, 0); tick(); x_stall_i = 0;
      peek(MSCR); chk("stall_nowrite", x_rd_o, 32'hFF);
      x_kill_i = 1; csr(RW, MSCR, 32'h0, 0); tick(); x_kill_i = 0;
      peek(MSCR); chk("kill_nowrite", x_rd_o, 32'hFF);
      csr(RCI, MSCR, 32'hFFFF_FFFF, 5'h0F);
      chk("rci_wval", x_csr_write_value_o, 32'hF0);
      tick();
      peek(MSCR); chk("rci_result", x_rd_o, 32'hF0);
      csr(RW, SCR1, 32'h123, 0); tick();
      peek(SCR1); chk("scratch1_absent", x_rd_o, 0);
      // counters and pass-through
      peek(12'hC80); chk("cyclesh", x_rd_o, 32'h0000_ABCD);
      peek(12'hC00); chk("cyclesl", x_rd_o, 32'h1234_5678);
      peek(12'hC81); chk("timeh", x_rd_o, 32'h0000_0001);
      peek(12'hC01); chk("timel", x_rd_o, 32'h8765_4321);
      peek(12'h341); chk("mepc", x_rd_o, 32'hDEAD_BEE0);
      peek(12'h342); chk("mcause", x_rd_o, 32'h8000_0007);
      peek(12'h123); chk("unmapped", x_rd_o, 0);
      // host-to-core fill
      for (int i = 0; i < 4; i++) begin
         dbg_h2c_valid_i = 1; dbg_h2c_data_i = 32'hA000_0000 + i;
         tick();
      end
      dbg_h2c_data_i = 32'hBAD0_BAD0; tick();
      dbg_h2c_valid_i = 0;
      chk("h2c_full_ready", 32'(dbg_h2c_ready_o), 0);
      chk("h2c_irq", 32'(mbx_irq_o), 1);
      peek(STAT); chk("stat_h2c4", x_rd_o, 32'h0000_0401);
      for (int i = 0; i < 4; i++) begin
         csr(RS, DBG, 0, 0);
         chk($sformatf("h2c_pop%0d", i), x_rd_o, 32'hA000_0000 + i);
         tick();
      end
      peek(DBG);
      chk("irq_lag", 32'(mbx_irq_o), 1);
      chk("dbg_empty", x_rd_o, 0);
      tick();
      chk("irq_drop", 32'(mbx_irq_o), 0);
      // core-to-host overflow
      for (int i = 0; i < 5; i++) begin
         csr(RW, DBG, 32'hB000_0000 + i, 0); tick();
      end
      d_is_csr_i = 0;
      chk("c2h_valid", 32'(dbg_c2h_valid_o), 1);
      chk("c2h_head", dbg_c2h_data_o, 32'hB000_0000);
      peek(STAT); chk("stat_ovf", x_rd_o, 32'h0004_0006);
      csr(RC, STAT, 32'h4, 0);
      chk("clr_wval", x_csr_write_value_o, 32'h0004_0002);
      tick();
      peek(STAT); chk("stat_ovf_clr", x_rd_o, 32'h0004_0002);
      // full c2h: core push and host pop together
      dbg_c2h_ready_i = 1; csr(RW, DBG, 32'hB000_0005, 0); tick();
      dbg_c2h_ready_i = 0; d_is_csr_i = 0;
      peek(STAT); chk("stat_pushpop_full", x_rd_o, 32'h0003_0004);
      chk("c2h_head2", dbg_c2h_data_o, 32'hB000_0001);
      // h2c simultaneous push/pop at level 2
      for (int i = 0; i < 2; i++) begin
         dbg_h2c_valid_i = 1; dbg_h2c_data_i = 32'hC000_0000 + i; tick();
      end
      dbg_h2c_data_i = 32'hC000_0002; csr(RS, DBG, 0, 0);
      chk("h2c_pp_rd", x_rd_o, 32'hC000_0000);
      tick();
      dbg_h2c_valid_i = 0;
      peek(STAT); chk("stat_h2c_pp", x_rd_o, 32'h0003_0205);
      peek(DBG); chk("h2c_head_c1", x_rd_o, 32'hC000_0001);
      dbg_c2h_ready_i = 1; tick(); dbg_c2h_ready_i = 0;
      chk("c2h_head3", dbg_c2h_data_o, 32'hB000_0002);
      peek(STAT); chk("stat_lvl22", x_rd_o, 32'h0002_0205);
      // asynchronous reset mid-cycle
      #2 rst_n_i = 0; dbg_h2c_valid_i = 1;
      #1;
      chk("arst_c2h_valid", 32'(dbg_c2h_valid_o), 0);
      chk("arst_c2h_data", dbg_c2h_data_o, 0);
      chk("arst_ready", 32'(dbg_h2c_ready_o), 1);
      chk("arst_irq", 32'(mbx_irq_o), 0);
      peek(MSCR); chk("arst_mscratch", x_rd_o, 0);
      tick();
      dbg_h2c_valid_i = 0;
      #2 rst_n_i = 1;
      tick();
      peek(STAT); chk("post_rst_stat", x_rd_o, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/urv_csr_mbx.md
URV_CSR_MBX -- requirements
Module: urv_csr_mbx

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- g_counter_width, 40, width of time/cycle counters (legal 33..64)
- g_num_scratch, 1, number of scratch CSRs (legal 1..4)
- g_mbx_depth, 4, entries per mailbox FIFO (power of 2, 2..16)
- g_with_hw_debug, 1, 0 removes both mailboxes
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- x_stall_i  in  1  execute stage stalled
- x_kill_i  in  1  execute stage killed
- d_is_csr_i  in  1  decoded instruction is a CSR access
- d_fun_i  in  3  CSR op (CSRRW/S/C, CSRRWI/SI/CI encodings)
- d_csr_imm_i  in  5  zimm
- d_csr_sel_i  in  12  CSR address
- d_rs1_i  in  32  rs1 value
- x_rd_o  out  32  CSR read value
- x_csr_write_value_o  out  32  computed write value
- csr_time_i, csr_cycles_i  in  g_counter_width  counters
- csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i  in  32  pass-through CSRs
- dbg_h2c_data_i  in  32  host-to-core word
- dbg_h2c_valid_i  in  1  host-to-core word offered
- dbg_h2c_ready_o  out  1  host-to-core FIFO not full
- dbg_c2h_data_o  out  32  core-to-host FIFO head
- dbg_c2h_valid_o  out  1  core-to-host FIFO not empty
- dbg_c2h_ready_i  in  1  host consumes head
- mbx_irq_o  out  1  registered: host-to-core FIFO not empty
REQ-003 Clock is clk_i only; reset is rst_n_i, asynchronous assert, active-low.

Function
REQ-004 Read mux (combinational on d_csr_sel_i) SHALL return: CYCLESL/TIMEL bits[31:0]; CYCLESH/TIMEH bits[W-1:32] zero-extended; MSCRATCH; SCRATCH1..3 at 0x7C1..0x7C3 (index < g_num_scratch, else 0); MEPC/MSTATUS/MCAUSE/MIP/MIE pass-through; DBGMBX = h2c head (0 if empty); MBXSTAT (0x7C8); others 0.
REQ-005 Write value: CSRRW(I) = operand; CSRRS(I) = read | operand; CSRRC(I) = read & ~operand; immediate ops use {27'b0, d_csr_imm_i}, others d_rs1_i.
REQ-006 Commit SHALL be d_is_csr_i & !x_stall_i & !x_kill_i; no state changes without commit.
REQ-007 Committed write to MSCRATCH/SCRATCHn SHALL update that register next edge; read-only counters and pass-through CSRs ignore writes.
REQ-008 Any committed access to DBGMBX SHALL pop h2c if non-empty; empty pop is a no-op.
REQ-009 Committed CSRRW/CSRRWI to DBGMBX SHALL push write value into c2h if not full at start of cycle; else drop word and set sticky overflow.
REQ-010 MBXSTAT: bit0 h2c non-empty, bit1 c2h full, bit2 overflow, [15:8] h2c level, [23:16] c2h level, rest 0; committed write with write value bit2=0 clears overflow; other bits read-only.
REQ-011 h2c push when dbg_h2c_valid_i & dbg_h2c_ready_o; dbg_h2c_ready_o = !full (current count).
REQ-012 c2h pop when dbg_c2h_valid_o & dbg_c2h_ready_i; dbg_c2h_data_o = head, 0 when empty.
REQ-013 Simultaneous push and pop on one FIFO: both take effect, level unchanged; on full c2h, core push still dropped (full judged pre-cycle) even if host pops.
REQ-014 Read pointers/levels wrap modulo g_mbx_depth without loss; level counter width log2(depth)+1.
REQ-015 mbx_irq_o SHALL equal registered h2c non-empty, one cycle after level change.
REQ-016 g_with_hw_debug=0: no FIFOs; ready/valid/irq = 0, DBGMBX/MBXSTAT read 0, writes ignored.

Reset
REQ-017 rst_n_i low SHALL immediately clear scratch registers, FIFO pointers/levels, overflow, mbx_irq_o; dbg_c2h_valid_o=0, dbg_c2h_data_o=0, dbg_h2c_ready_o=1 (debug enabled).
REQ-018 Reset asserted mid-transfer SHALL discard FIFO contents; no push/pop while rst_n_i low.

Verification
REQ-019 CSRRS MSCRATCH rs1=0x0F after CSRRW 0xF0 -> read 0xF0, MSCRATCH=0xFF; same op with x_stall_i=1 -> unchanged.
REQ-020 Host pushes 4 words (depth 4) -> ready_o=0, MBXSTAT[15:8]=4, irq=1; four DBGMBX reads return words in order, irq drops one cycle after last pop.
REQ-021 Five CSRRW to DBGMBX with host not ready -> c2h holds first four, MBXSTAT bit2=1; CSRRC MBXSTAT 0x4 -> bit2=0.
REQ-022 c2h full, core push and host pop same cycle -> level 3, overflow set; h2c push+pop at level 2 -> level stays 2.
REQ-023 g_counter_width=48, cycles=0xABCD_1234_5678 -> CYCLESH=0x0000ABCD, CYCLESL=0x12345678.
REQ-024 rst_n_i pulsed low asynchronously with both FIFOs at level 2 -> outputs reset without clock edge; levels 0 after release.
